spi_responder: RTL and testbench

- SPI peripheral (target) end of the team's 8-bit SPI link, the counterpart to the existing SPI master driver.
- Samples an externally driven SPI_CLK, SPI_EN and SPI_MOSI in the system clock domain using oversampling synchronizers.
- Shifts 8-bit words in from SPI_MOSI and out on SPI_MISO, MSB first, and supports back-to-back bytes within one SPI_EN assertion.
- Exposes a valid/ready transmit holding register and a one-cycle receive strobe toward the local host logic.

---
 rtl/spi_pkg.sv | 24 ++
 rtl/spi_sync.sv | 34 +++
 rtl/spi_responder.sv | 159 +++++++++++++++
 tb/tb_spi_responder.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI responder.
package spi_pkg;

    localparam int SPI_WIDTH = 8;
    localparam int CNT_W     = $clog2(SPI_WIDTH);

    // Byte shifted out when the host has no word pending.
    localparam logic [SPI_WIDTH-1:0] DEFAULT_TX = 8'hFF;

    // Bit counter value of the last bit in a byte.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPI_WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } resp_state_e;

    // MSB-first shift: drop the top bit, append the new bit at the bottom.
    function automatic logic [SPI_WIDTH-1:0] shift_in(input logic [SPI_WIDTH-1:0] cur,
                                                      input logic                 new_bit);
        return {cur[SPI_WIDTH-2:0], new_bit};
    endfunction

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchronizer with a previous-value flop for edge detection.
module spi_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Synchronizer chain plus delayed copy for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
            prev_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign q_o    = sync_q;
    assign rise_o = sync_q & ~prev_q;
    assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/spi_responder.sv
// SPI target (CPOL=0, sample on falling edge), 8-bit words, MSB first,
// with a host-side transmit holding register and a receive strobe.
module spi_responder
    import spi_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 SPI_CLK,
    input  logic                 SPI_EN,
    input  logic                 SPI_MOSI,
    output logic                 SPI_MISO,
    input  logic [SPI_WIDTH-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [SPI_WIDTH-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 busy
);

    logic sclk_s, sclk_rise_s, sclk_fall_s;
    logic en_s, en_rise_s, en_fall_s;
    logic mosi_s, mosi_rise_s, mosi_fall_s;
    logic unused_s;

    resp_state_e          state_q, state_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [SPI_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [SPI_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic [SPI_WIDTH-1:0] tx_hold_q, tx_hold_d;
    logic                 hold_full_q, hold_full_d;
    logic [SPI_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic                 from_hold_q, from_hold_d;

    spi_sync #(.RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .d_i(SPI_CLK),
        .q_o(sclk_s), .rise_o(sclk_rise_s), .fall_o(sclk_fall_s)
    );

    spi_sync #(.RST_VAL(1'b0)) u_sync_en (
        .clk(clk), .rst(rst), .d_i(SPI_EN),
        .q_o(en_s), .rise_o(en_rise_s), .fall_o(en_fall_s)
    );

    spi_sync #(.RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .d_i(SPI_MOSI),
        .q_o(mosi_s), .rise_o(mosi_rise_s), .fall_o(mosi_fall_s)
    );

    // Rising SCLK edges, MOSI edges and the EN rising pulse are not needed;
    // the EN level alone ends a frame.
    assign unused_s = sclk_s ^ sclk_rise_s ^ en_rise_s ^ mosi_rise_s ^ mosi_fall_s;

    // State, shift registers and host-facing registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            tx_hold_q   <= '0;
            hold_full_q <= 1'b0;
            tx_shift_q  <= '0;
            from_hold_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            tx_hold_q   <= tx_hold_d;
            hold_full_q <= hold_full_d;
            tx_shift_q  <= tx_shift_d;
            from_hold_q <= from_hold_d;
        end
    end

    // Next-state logic: host writes, frame start/abort, bit shifting, byte boundaries.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        tx_hold_d   = tx_hold_q;
        hold_full_d = hold_full_q;
        tx_shift_d  = tx_shift_q;
        from_hold_d = from_hold_q;

        // Host write only lands when the holding register is empty, so it can
        // never collide with a consumption below (which requires it full).
        if (tx_valid && !hold_full_q) begin
            tx_hold_d   = tx_data;
            hold_full_d = 1'b1;
        end else begin
            tx_hold_d   = tx_hold_q;
        end

        case (state_q)
            IDLE: begin
                if (en_s) begin
                    // Keep the first outgoing byte preloaded so bit 7 is ready
                    // the moment chip select falls.
                    tx_shift_d  = hold_full_q ? tx_hold_q : DEFAULT_TX;
                    from_hold_d = hold_full_q;
                end else if (en_fall_s) begin
                    state_d   = SHIFT;
                    bit_cnt_d = '0;
                    if (from_hold_q) begin
                        hold_full_d = 1'b0;
                    end else begin
                        hold_full_d = hold_full_d;
                    end
                end else begin
                    // EN low without a seen falling edge: stay out of the frame.
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (en_s) begin
                    // Abort: partial byte dropped; a consumed hold word stays consumed.
                    state_d     = IDLE;
                    bit_cnt_d   = '0;
                    from_hold_d = 1'b0;
                end else if (sclk_fall_s) begin
                    rx_shift_d = shift_in(rx_shift_q, mosi_s);
                    bit_cnt_d  = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == CNT_LAST) begin
                        rx_data_d  = shift_in(rx_shift_q, mosi_s);
                        rx_valid_d = 1'b1;
                        tx_shift_d = hold_full_q ? tx_hold_q : DEFAULT_TX;
                        if (hold_full_q) begin
                            hold_full_d = 1'b0;
                        end else begin
                            hold_full_d = hold_full_d;
                        end
                    end else begin
                        tx_shift_d = shift_in(tx_shift_q, 1'b0);
                    end
                end else begin
                    state_d = SHIFT;
                end
            end
            default: begin
                state_d   = IDLE;
                bit_cnt_d = '0;
            end
        endcase
    end

    // MISO uses the raw chip select so bit 7 appears without synchronizer delay.
    assign SPI_MISO = ~SPI_EN & tx_shift_q[SPI_WIDTH-1];
    assign tx_ready = ~hold_full_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = (state_q == SHIFT);

endmodule

// File: tb/tb_spi_responder.sv
// Self-checking bench for spi_responder: a bit-banged SPI master plus a
// word-level model of the holding register.
module tb_spi_responder;

    localparam logic [7:0] IDLE_BYTE = 8'hFF;
    localparam int         HALF      = 50;   // SCLK half period: 5 clk

    logic       clk;
    logic       rst;
    logic       SPI_CLK;
    logic       SPI_EN;
    logic       SPI_MOSI;
    logic       SPI_MISO;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;

    spi_responder dut (
        .clk(clk), .rst(rst),
        .SPI_CLK(SPI_CLK), .SPI_EN(SPI_EN), .SPI_MOSI(SPI_MOSI), .SPI_MISO(SPI_MISO),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;

    // Log of every received byte; a stuck strobe shows up as extra entries.
    logic [7:0] rx_log [256];
    int         rx_cnt = 0;

    always @(negedge clk) begin
        if (rx_valid) begin
            if (rx_cnt < 256) rx_log[rx_cnt] <= rx_data;
            rx_cnt <= rx_cnt + 1;
        end
    end

    // Model of the host holding register: one word, accepted only when empty.
    bit         pend_v = 1'b0;
    logic [7:0] pend_d = 8'h00;

    logic [7:0] mbytes [4];
    logic [7:0] got    [4];
    logic [7:0] exp_b  [4];
    logic       rdy_mid;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    endtask

    // One-cycle host write attempt; the model accepts it only if empty.
    task automatic host_write(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        if (!pend_v) begin
            pend_v = 1'b1;
            pend_d = d;
        end
        #10;
        tx_valid = 1'b0;
    endtask

    // One SPI bit: MOSI changes with the rising edge, MISO sampled just before the fall.
    task automatic do_bit(input logic mosi, output logic miso);
        SPI_CLK  = 1'b1;
        SPI_MOSI = mosi;
        #HALF;
        miso    = SPI_MISO;
        SPI_CLK = 1'b0;
        #HALF;
    endtask

    // Frame of nbits bits; optionally a host write during the first byte.
    task automatic frame(input int nbits, input bit do_mid, input logic [7:0] mid_val);
        SPI_EN = 1'b0;
        #HALF;
        rdy_mid = tx_ready;
        fork
            begin
                for (int i = 0; i < nbits; i++) begin
                    logic m;
                    do_bit(mbytes[i/8][7-(i%8)], m);
                    got[i/8][7-(i%8)] = m;
                end
            end
            begin
                if (do_mid) begin
                    #300;
                    host_write(mid_val);
                end
            end
        join
        #HALF;
        SPI_EN   = 1'b1;
        SPI_MOSI = 1'b0;
    endtask

    // Full frame of nb bytes, checked against the holding-register model.
    task automatic run_and_check(input int nb, input bit mid, input logic [7:0] mv,
                                 input string tag);
        int start;
        if (pend_v) check({tag, "_ready_full"}, 32'(tx_ready), 32'd0);
        exp_b[0] = pend_v ? pend_d : IDLE_BYTE;
        pend_v   = 1'b0;
        start    = rx_cnt;
        frame(nb * 8, mid, mv);
        check({tag, "_ready_after_en"}, 32'(rdy_mid), 32'd1);
        // Any mid-frame write landed during byte 0, so it serves byte 1.
        exp_b[1] = pend_v ? pend_d : IDLE_BYTE;
        pend_v   = 1'b0;
        exp_b[2] = IDLE_BYTE;
        exp_b[3] = IDLE_BYTE;
        #100;
        check({tag, "_rx_count"}, 32'(rx_cnt - start), 32'(nb));
        for (int k = 0; k < nb; k++) begin
            check({tag, "_rx_byte"}, 32'(rx_log[start + k]), 32'(mbytes[k]));
            check({tag, "_miso_byte"}, 32'(got[k]), 32'(exp_b[k]));
        end
    endtask

    initial begin
        int         c0;
        logic       miso_or;
        logic       m;
        logic [7:0] w1;

        rst      = 1'b1;
        SPI_CLK  = 1'b0;
        SPI_EN   = 1'b1;
        SPI_MOSI = 1'b0;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        #20;
        check("rst_miso",     32'(SPI_MISO), 32'd0);
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        check("rst_rx_data",  32'(rx_data),  32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_busy",     32'(busy),     32'd0);
        #20;
        rst = 1'b0;
        #100;

        // Preloaded host word, master sends A5.
        host_write(8'h3C);
        #50;
        mbytes[0] = 8'hA5;
        run_and_check(1, 1'b0, 8'h00, "t1");

        // No host word: default byte goes out.
        mbytes[0] = 8'h00;
        run_and_check(1, 1'b0, 8'h00, "t2");

        // Two bytes, host refills during byte 1.
        host_write(8'($urandom));
        #50;
        mbytes[0] = 8'h12;
        mbytes[1] = 8'h34;
        run_and_check(2, 1'b1, 8'h56, "t3");

        // Abort after 5 bits.
        mbytes[0] = 8'($urandom);
        c0 = rx_cnt;
        frame(5, 1'b0, 8'h00);
        #20;
        check("abort_busy_held", 32'(busy), 32'd1);
        #10;
        check("abort_busy_drop", 32'(busy), 32'd0);
        #100;
        check("abort_no_rx", 32'(rx_cnt - c0), 32'd0);
        mbytes[0] = 8'h81;
        run_and_check(1, 1'b0, 8'h00, "t4");

        // Reset mid-byte with chip select held low.
        SPI_EN = 1'b0;
        #HALF;
        for (int i = 0; i < 3; i++) do_bit(1'b1, m);
        rst = 1'b1;
        #20;
        check("midrst_miso",     32'(SPI_MISO), 32'd0);
        check("midrst_tx_ready", 32'(tx_ready), 32'd1);
        check("midrst_rx_data",  32'(rx_data),  32'd0);
        check("midrst_rx_valid", 32'(rx_valid), 32'd0);
        check("midrst_busy",     32'(busy),     32'd0);
        rst    = 1'b0;
        pend_v = 1'b0;
        c0      = rx_cnt;
        miso_or = 1'b0;
        for (int i = 0; i < 12; i++) begin
            do_bit(1'($urandom), m);
            miso_or = miso_or | m;
        end
        check("ensticky_no_rx", 32'(rx_cnt - c0), 32'd0);
        check("ensticky_miso",  32'(miso_or),     32'd0);
        check("ensticky_busy",  32'(busy),        32'd0);
        SPI_EN = 1'b1;
        #100;
        mbytes[0] = 8'($urandom);
        run_and_check(1, 1'b0, 8'h00, "t5");

        // Write attempts while the holding register is full are ignored.
        w1 = 8'($urandom);
        host_write(w1);
        #20;
        check("full_ready_low", 32'(tx_ready), 32'd0);
        for (int i = 0; i < 3; i++) host_write(~w1);
        check("full_ready_still_low", 32'(tx_ready), 32'd0);
        #30;
        mbytes[0] = 8'($urandom);
        run_and_check(1, 1'b0, 8'h00, "t6");
        check("full_ready_back", 32'(tx_ready), 32'd1);

        // Randomized frames.
        for (int f = 0; f < 6; f++) begin
            int nb;
            bit mid;
            nb  = int'($urandom_range(1, 3));
            mid = (nb > 1) && ($urandom_range(0, 1) == 1);
            for (int k = 0; k < 4; k++) mbytes[k] = 8'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                host_write(8'($urandom));
                #50;
            end
            run_and_check(nb, mid, 8'($urandom), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
